// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the registered N:1 stream multiplexer.
// Imported by the interface, the round-robin arbiter and the top level.
package stream_mux_pkg;

  typedef enum logic {MODE_SELECT = 1'b0, MODE_RR = 1'b1} mux_mode_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} mux_state_t;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_CHANNELS = 4;

  // Width of a channel index; never zero so single-bit selects stay legal.
  function automatic int sel_width(input int channels);
    return (channels < 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Producer/consumer bundle of the stream multiplexer.
// master drives the producer inputs and consumer ready; slave is the mux itself.
interface stream_mux_if
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS
);
  localparam int SELW = sel_width(CHANNELS);

  mux_mode_t                  mode;
  logic [SELW-1:0]            sel;
  logic [CHANNELS-1:0]        in_valid;
  logic [CHANNELS*WIDTH-1:0]  in_data;
  logic [CHANNELS-1:0]        in_last;
  logic [CHANNELS-1:0]        in_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic                       out_last;
  logic [SELW-1:0]            out_chan;
  logic                       out_ready;

  modport master (
    output mode, sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_chan
  );

  modport slave (
    input  mode, sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_chan
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester after
// last_grant, wrapping modulo N.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = DEFAULT_CHANNELS
) (
  input  logic [N-1:0]              req,
  input  logic [sel_width(N)-1:0]   last_grant,
  output logic                      gnt_valid,
  output logic [sel_width(N)-1:0]   gnt_idx
);
  localparam int IW = sel_width(N);

  logic [IW-1:0] probe;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    probe     = '0;
    for (int i = 1; i <= N; i++) begin
      probe = IW'((int'(last_grant) + i) % N);
      if (!gnt_valid && req[probe]) begin
        gnt_valid = 1'b1;
        gnt_idx   = probe;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// Registered N:1 valid/ready stream multiplexer with packet locking.
// Channel is chosen by sel or round-robin while idle; a grant holds until the last beat.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic        clock,
  input  logic        nreset,
  stream_mux_if.slave bus
);
  localparam int SELW = sel_width(CHANNELS);

  mux_state_t           state, state_next;
  logic [SELW-1:0]      grant, grant_next;
  logic [SELW-1:0]      rr_last, rr_last_next;

  logic                 out_valid_q, out_last_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [SELW-1:0]      out_chan_q;

  logic                 stage_ready;
  logic [31:0]          sel_ext;
  logic                 arb_valid;
  logic [SELW-1:0]      arb_idx;
  logic                 cand_valid;
  logic [SELW-1:0]      cand_idx;
  logic [SELW-1:0]      act_idx;
  logic [CHANNELS-1:0]  ready_vec;
  logic                 xfer;
  logic                 xfer_last;
  logic [WIDTH-1:0]     xfer_data;

  rr_arbiter #(.N(CHANNELS)) u_arb (
    .req        (bus.in_valid),
    .last_grant (rr_last),
    .gnt_valid  (arb_valid),
    .gnt_idx    (arb_idx)
  );

  // Holding nreset low also forces every in_ready low, not just the registers.
  assign stage_ready = nreset & (!out_valid_q | bus.out_ready);
  assign sel_ext     = 32'(bus.sel);

  // Out-of-range sel simply never matches a channel, so it yields no grant.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    if (bus.mode == MODE_RR) begin
      cand_valid = arb_valid;
      cand_idx   = arb_idx;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel_ext == 32'(k) && bus.in_valid[k]) begin
          cand_valid = 1'b1;
          cand_idx   = SELW'(k);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state   <= ST_IDLE;
      grant   <= '0;
      rr_last <= SELW'(CHANNELS - 1);
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      rr_last <= rr_last_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    rr_last_next = rr_last;
    ready_vec    = '0;
    act_idx      = grant;
    xfer_last    = 1'b0;
    xfer_data    = '0;

    case (state)
      ST_IDLE: begin
        act_idx = cand_idx;
        if (cand_valid) ready_vec[cand_idx] = stage_ready;
      end
      ST_LOCKED: begin
        ready_vec[grant] = stage_ready;
      end
      default: ;
    endcase

    for (int k = 0; k < CHANNELS; k++) begin
      if (act_idx == SELW'(k)) begin
        xfer_last = bus.in_last[k];
        xfer_data = bus.in_data[k*WIDTH +: WIDTH];
      end
    end

    xfer = |(bus.in_valid & ready_vec);

    // rr_last follows every completed packet so RR stays fair across mode switches.
    if (xfer) begin
      if (xfer_last) begin
        state_next   = ST_IDLE;
        rr_last_next = act_idx;
      end else if (state == ST_IDLE) begin
        state_next = ST_LOCKED;
        grant_next = act_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
    end else if (stage_ready) begin
      out_valid_q <= xfer;
      if (xfer) begin
        out_data_q <= xfer_data;
        out_last_q <= xfer_last;
        out_chan_q <= act_idx;
      end
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_chan  = out_chan_q;

endmodule
